// File: rtl/axis_frame_len_stats.sv
// Frame-length statistics collector: accumulates per-interval frame counts and length
// stats, and publishes them as snapshots over a valid/ready handshake.
module axis_frame_len_stats #(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int BYTES_WIDTH = 48,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic                   frame_len_valid,
  input  logic                   snapshot_req,
  input  logic                   clear_on_snapshot,
  output logic [COUNT_WIDTH-1:0] stat_frames,
  output logic [BYTES_WIDTH-1:0] stat_bytes,
  output logic [LEN_WIDTH-1:0]   stat_min_len,
  output logic [LEN_WIDTH-1:0]   stat_max_len,
  output logic [COUNT_WIDTH-1:0] stat_runt,
  output logic [COUNT_WIDTH-1:0] stat_oversize,
  output logic                   stat_overrun,
  output logic                   stat_valid,
  input  logic                   stat_ready
);

  localparam logic [LEN_WIDTH-1:0] MinLenL = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MaxLenL = LEN_WIDTH'(MAX_LEN);

  logic [COUNT_WIDTH-1:0] frames_q, frames_d, runt_q, runt_d, over_q, over_d;
  logic [BYTES_WIDTH-1:0] bytes_q, bytes_d;
  logic [LEN_WIDTH-1:0]   minLen_q, minLen_d, maxLen_q, maxLen_d;
  logic                   pendDrop_q, pendDrop_d;
  logic [BYTES_WIDTH:0]   bytesSum;

  logic [COUNT_WIDTH-1:0] statFrames_q, statFrames_d, statRunt_q, statRunt_d;
  logic [COUNT_WIDTH-1:0] statOver_q, statOver_d;
  logic [BYTES_WIDTH-1:0] statBytes_q, statBytes_d;
  logic [LEN_WIDTH-1:0]   statMin_q, statMin_d, statMax_q, statMax_d;
  logic                   statOverrun_q, statOverrun_d, statValid_q, statValid_d;
  logic                   accept;

  function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // A snapshot can be taken whenever the output slot is empty or being drained this cycle
  assign accept = snapshot_req && (!statValid_q || stat_ready);

  // Live accumulators: optional interval restart first, so a coincident frame opens the new interval
  always_comb begin
    frames_d = frames_q;
    bytes_d  = bytes_q;
    minLen_d = minLen_q;
    maxLen_d = maxLen_q;
    runt_d   = runt_q;
    over_d   = over_q;
    bytesSum = '0;
    if (accept && clear_on_snapshot) begin
      frames_d = '0;
      bytes_d  = '0;
      minLen_d = '1;
      maxLen_d = '0;
      runt_d   = '0;
      over_d   = '0;
    end
    if (frame_len_valid) begin
      frames_d = satInc(frames_d);
      bytesSum = {1'b0, bytes_d} + (BYTES_WIDTH + 1)'(frame_len);
      bytes_d  = bytesSum[BYTES_WIDTH] ? '1 : bytesSum[BYTES_WIDTH-1:0];
      if (frame_len < minLen_d) minLen_d = frame_len;
      if (frame_len > maxLen_d) maxLen_d = frame_len;
      if (frame_len < MinLenL) runt_d = satInc(runt_d);
      if (frame_len > MaxLenL) over_d = satInc(over_d);
    end
  end

  // Published snapshot captures the pre-update live values and the drop history
  always_comb begin
    statFrames_d  = statFrames_q;
    statBytes_d   = statBytes_q;
    statMin_d     = statMin_q;
    statMax_d     = statMax_q;
    statRunt_d    = statRunt_q;
    statOver_d    = statOver_q;
    statOverrun_d = statOverrun_q;
    statValid_d   = statValid_q;
    pendDrop_d    = pendDrop_q;
    if (accept) begin
      statFrames_d  = frames_q;
      statBytes_d   = bytes_q;
      statMin_d     = minLen_q;
      statMax_d     = maxLen_q;
      statRunt_d    = runt_q;
      statOver_d    = over_q;
      statOverrun_d = pendDrop_q;
      statValid_d   = 1'b1;
      pendDrop_d    = 1'b0;
    end else begin
      if (snapshot_req) pendDrop_d = 1'b1;
      if (statValid_q && stat_ready) statValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q      <= '0;
      bytes_q       <= '0;
      minLen_q      <= '1;
      maxLen_q      <= '0;
      runt_q        <= '0;
      over_q        <= '0;
      pendDrop_q    <= 1'b0;
      statFrames_q  <= '0;
      statBytes_q   <= '0;
      statMin_q     <= '0;
      statMax_q     <= '0;
      statRunt_q    <= '0;
      statOver_q    <= '0;
      statOverrun_q <= 1'b0;
      statValid_q   <= 1'b0;
    end else begin
      frames_q      <= frames_d;
      bytes_q       <= bytes_d;
      minLen_q      <= minLen_d;
      maxLen_q      <= maxLen_d;
      runt_q        <= runt_d;
      over_q        <= over_d;
      pendDrop_q    <= pendDrop_d;
      statFrames_q  <= statFrames_d;
      statBytes_q   <= statBytes_d;
      statMin_q     <= statMin_d;
      statMax_q     <= statMax_d;
      statRunt_q    <= statRunt_d;
      statOver_q    <= statOver_d;
      statOverrun_q <= statOverrun_d;
      statValid_q   <= statValid_d;
    end
  end

  assign stat_frames   = statFrames_q;
  assign stat_bytes    = statBytes_q;
  assign stat_min_len  = statMin_q;
  assign stat_max_len  = statMax_q;
  assign stat_runt     = statRunt_q;
  assign stat_oversize = statOver_q;
  assign stat_overrun  = statOverrun_q;
  assign stat_valid    = statValid_q;

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Bench for axis_frame_len_stats: directed vector table, saturation and reset sequences,
// then random traffic against a queue-based reference model.
module tb_axis_frame_len_stats;

  typedef struct {
    logic        valid;
    logic [31:0] frames;
    logic [47:0] bytes;
    logic [15:0] minLen;
    logic [15:0] maxLen;
    logic [31:0] runt;
    logic [31:0] over;
    logic        overrun;
    logic        chkData;
  } expT;

  typedef struct {
    logic        fv;
    logic [15:0] len;
    logic        snap;
    logic        clr;
    logic        rdy;
    expT         exp;
  } vecT;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] frameLen;
  logic frameLenValid, snapReq, clearOnSnap, statReady;
  logic [31:0] statFrames, statRunt, statOver;
  logic [47:0] statBytes;
  logic [15:0] statMin, statMax;
  logic statOverrun, statValid;

  logic [15:0] sFrameLen;
  logic sFrameLenValid, sSnapReq, sClearOnSnap, sStatReady;
  logic [3:0] sFrames, sRunt, sOver;
  logic [47:0] sBytes;
  logic [15:0] sMin, sMax;
  logic sOverrun, sValid;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  axis_frame_len_stats dut (
    .clk(clk), .rst(rst), .frame_len(frameLen), .frame_len_valid(frameLenValid),
    .snapshot_req(snapReq), .clear_on_snapshot(clearOnSnap),
    .stat_frames(statFrames), .stat_bytes(statBytes), .stat_min_len(statMin),
    .stat_max_len(statMax), .stat_runt(statRunt), .stat_oversize(statOver),
    .stat_overrun(statOverrun), .stat_valid(statValid), .stat_ready(statReady)
  );

  axis_frame_len_stats #(.COUNT_WIDTH(4)) dutSmall (
    .clk(clk), .rst(rst), .frame_len(sFrameLen), .frame_len_valid(sFrameLenValid),
    .snapshot_req(sSnapReq), .clear_on_snapshot(sClearOnSnap),
    .stat_frames(sFrames), .stat_bytes(sBytes), .stat_min_len(sMin),
    .stat_max_len(sMax), .stat_runt(sRunt), .stat_oversize(sOver),
    .stat_overrun(sOverrun), .stat_valid(sValid), .stat_ready(sStatReady)
  );

  function automatic expT noData();
    expT e;
    e = '{valid: 1'b0, frames: 0, bytes: 0, minLen: 0, maxLen: 0, runt: 0, over: 0,
          overrun: 1'b0, chkData: 1'b0};
    return e;
  endfunction

  function automatic expT snapExp(int fr, longint by, int mn, int mx, int ru, int ov, bit ovr);
    expT e;
    e = '{valid: 1'b1, frames: 32'(fr), bytes: 48'(by), minLen: 16'(mn), maxLen: 16'(mx),
          runt: 32'(ru), over: 32'(ov), overrun: ovr, chkData: 1'b1};
    return e;
  endfunction

  function automatic vecT mkVec(bit fv, int len, bit snap, bit clr, bit rdy, expT e);
    vecT v;
    v = '{fv: fv, len: 16'(len), snap: snap, clr: clr, rdy: rdy, exp: e};
    return v;
  endfunction

  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input expT e);
    compareField({tag, ".valid"}, 64'(statValid), 64'(e.valid));
    if (e.chkData) begin
      compareField({tag, ".frames"}, 64'(statFrames), 64'(e.frames));
      compareField({tag, ".bytes"}, 64'(statBytes), 64'(e.bytes));
      compareField({tag, ".min"}, 64'(statMin), 64'(e.minLen));
      compareField({tag, ".max"}, 64'(statMax), 64'(e.maxLen));
      compareField({tag, ".runt"}, 64'(statRunt), 64'(e.runt));
      compareField({tag, ".oversize"}, 64'(statOver), 64'(e.over));
      compareField({tag, ".overrun"}, 64'(statOverrun), 64'(e.overrun));
    end
  endtask

  task automatic applyStimulus(input bit fv, input logic [15:0] len, input bit snap,
                               input bit clr, input bit rdy);
    frameLenValid = fv;
    frameLen      = len;
    snapReq       = snap;
    clearOnSnap   = clr;
    statReady     = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the frames of the current interval are kept as a plain list
  int unsigned liveQ[$];
  function automatic expT statsOf(bit ovr);
    expT e;
    longint sum = 0;
    int n = 0, ru = 0, ov = 0, mn = 65535, mx = 0;
    foreach (liveQ[i]) begin
      n++;
      sum += liveQ[i];
      if (liveQ[i] < mn) mn = liveQ[i];
      if (liveQ[i] > mx) mx = liveQ[i];
      if (liveQ[i] < 64) ru++;
      if (liveQ[i] > 1518) ov++;
    end
    e = snapExp(n, sum, mn, mx, ru, ov, ovr);
    return e;
  endfunction

  vecT vecs[21];
  expT zeroExp, modelSnap;
  bit mValid, mDrop, fv, snap, clr, rdy;
  int unsigned len;

  initial begin
    rst = 1'b1;
    frameLen = '0; frameLenValid = 1'b0; snapReq = 1'b0; clearOnSnap = 1'b0; statReady = 1'b0;
    sFrameLen = '0; sFrameLenValid = 1'b0; sSnapReq = 1'b0; sClearOnSnap = 1'b0; sStatReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    zeroExp = '{valid: 1'b0, frames: 0, bytes: 0, minLen: 0, maxLen: 0, runt: 0, over: 0,
                overrun: 1'b0, chkData: 1'b1};
    checkOutput("reset", zeroExp);
    rst = 1'b0;

    $display("[TB] counter saturation with COUNT_WIDTH=4");
    for (int i = 0; i < 17; i++) begin
      sFrameLen = 16'd10; sFrameLenValid = 1'b1;
      @(posedge clk); #1;
    end
    sFrameLenValid = 1'b0; sSnapReq = 1'b1;
    @(posedge clk); #1;
    sSnapReq = 1'b0;
    compareField("sat.valid", 64'(sValid), 64'd1);
    compareField("sat.frames", 64'(sFrames), 64'd15);
    compareField("sat.runt", 64'(sRunt), 64'd15);
    compareField("sat.bytes", 64'(sBytes), 64'd170);
    compareField("sat.min", 64'(sMin), 64'd10);
    compareField("sat.max", 64'(sMax), 64'd10);

    $display("[TB] directed vector table");
    vecs[0]  = mkVec(1, 100,  0, 0, 0, noData());
    vecs[1]  = mkVec(1, 60,   0, 0, 0, noData());
    vecs[2]  = mkVec(1, 2000, 0, 0, 0, noData());
    vecs[3]  = mkVec(0, 0,    1, 0, 0, snapExp(3, 2160, 60, 2000, 1, 1, 0));
    vecs[4]  = mkVec(0, 0,    0, 0, 1, noData());
    vecs[5]  = mkVec(1, 70,   1, 1, 0, snapExp(3, 2160, 60, 2000, 1, 1, 0));
    vecs[6]  = mkVec(0, 0,    1, 0, 1, snapExp(1, 70, 70, 70, 0, 0, 0));
    vecs[7]  = mkVec(0, 0,    1, 0, 0, snapExp(1, 70, 70, 70, 0, 0, 0));
    vecs[8]  = mkVec(1, 64,   1, 1, 0, snapExp(1, 70, 70, 70, 0, 0, 0));
    vecs[9]  = mkVec(0, 0,    0, 0, 1, noData());
    vecs[10] = mkVec(0, 0,    1, 0, 0, snapExp(2, 134, 64, 70, 0, 0, 1));
    vecs[11] = mkVec(0, 0,    1, 1, 1, snapExp(2, 134, 64, 70, 0, 0, 0));
    vecs[12] = mkVec(0, 0,    0, 0, 1, noData());
    vecs[13] = mkVec(1, 63,   0, 0, 0, noData());
    vecs[14] = mkVec(1, 64,   0, 0, 0, noData());
    vecs[15] = mkVec(1, 1518, 0, 0, 0, noData());
    vecs[16] = mkVec(1, 1519, 0, 0, 0, noData());
    vecs[17] = mkVec(0, 0,    1, 1, 0, snapExp(4, 3164, 63, 1519, 1, 1, 0));
    vecs[18] = mkVec(0, 0,    0, 0, 1, noData());
    vecs[19] = mkVec(0, 0,    1, 0, 0, snapExp(0, 0, 65535, 0, 0, 0, 0));
    vecs[20] = mkVec(0, 0,    0, 0, 1, noData());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fv, vecs[i].len, vecs[i].snap, vecs[i].clr, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    $display("[TB] reset mid-interval with a frame and snapshot request pending");
    applyStimulus(1, 16'd100, 0, 0, 0);
    applyStimulus(0, 16'd0, 1, 0, 0);
    checkOutput("preRst", snapExp(1, 100, 100, 100, 0, 0, 0));
    applyStimulus(1, 16'd200, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 16'd300, 1, 0, 0);
    rst = 1'b0;
    checkOutput("inRst", zeroExp);
    applyStimulus(0, 16'd0, 1, 0, 0);
    checkOutput("postRst", snapExp(0, 0, 65535, 0, 0, 0, 0));
    applyStimulus(0, 16'd0, 0, 0, 1);
    checkOutput("postRstDrain", noData());

    $display("[TB] random traffic against reference model");
    rst = 1'b1;
    applyStimulus(0, 16'd0, 0, 0, 0);
    rst = 1'b0;
    liveQ.delete();
    mValid = 1'b0;
    mDrop = 1'b0;
    modelSnap = noData();
    for (int cyc = 0; cyc < 600; cyc++) begin
      fv   = ($urandom_range(0, 99) < 60);
      len  = ($urandom_range(0, 19) == 0) ? 65535 : $urandom_range(0, 2500);
      snap = ($urandom_range(0, 99) < 20);
      clr  = $urandom_range(0, 1);
      rdy  = ($urandom_range(0, 99) < 40);
      if (snap && (!mValid || rdy)) begin
        modelSnap = statsOf(mDrop);
        mDrop = 1'b0;
        mValid = 1'b1;
        if (clr) liveQ.delete();
      end else begin
        if (snap) mDrop = 1'b1;
        if (mValid && rdy) mValid = 1'b0;
      end
      if (fv) liveQ.push_back(len);
      applyStimulus(fv, 16'(len), snap, clr, rdy);
      if (mValid) checkOutput($sformatf("rnd%0d", cyc), modelSnap);
      else        checkOutput($sformatf("rnd%0d", cyc), noData());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
